// File: rtl/fifo_in_controller.sv
// Pointer, occupancy and status control for the 8-entry input FIFO, plus the registered pop-data stage.
// Optional almost_full/almost_empty outputs are enabled by defining FIFO_IN_ALMOST_FLAGS_EN.
module fifo_in_controller #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [DATA_W-1:0] rData,
    output logic              we,
    output logic [ADDR_W-1:0] wAddr,
    output logic [ADDR_W-1:0] rAddr,
    output logic [DATA_W-1:0] d_out,
    output logic              full,
    output logic              empty,
    output logic              wr_ack,
    output logic              wr_err,
    output logic              rd_ack,
    output logic              rd_err,
    output logic [ADDR_W:0]   data_count
`ifdef FIFO_IN_ALMOST_FLAGS_EN
    ,
    output logic              almost_full,
    output logic              almost_empty
`endif
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH = CNT_W'(1 << ADDR_W);

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD,
        WR_RD,
        WR_ERR,
        RD_ERR,
        WR_RD_ERR
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              err_rd;
    logic              err_rd_next;
    logic [ADDR_W-1:0] head;
    logic [ADDR_W-1:0] tail;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_next;
    logic              push_ok;
    logic              pop_ok;

    assign full    = (count == DEPTH);
    assign empty   = (count == CNT_W'(0));
    assign push_ok = wr_en & ~full;
    assign pop_ok  = rd_en & ~empty;

    assign we         = push_ok;
    assign wAddr      = tail;
    assign rAddr      = head;
    assign data_count = count;

`ifdef FIFO_IN_ALMOST_FLAGS_EN
    assign almost_full  = (count >= DEPTH - CNT_W'(1));
    assign almost_empty = (count <= CNT_W'(1));
`endif

    // err_rd distinguishes which side failed when the state is WR_RD_ERR
    assign wr_ack = (state == WR) || (state == WR_RD) || ((state == WR_RD_ERR) && err_rd);
    assign wr_err = (state == WR_ERR) || ((state == WR_RD_ERR) && !err_rd);
    assign rd_ack = (state == RD) || (state == WR_RD) || ((state == WR_RD_ERR) && !err_rd);
    assign rd_err = (state == RD_ERR) || ((state == WR_RD_ERR) && err_rd);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            err_rd <= 1'b0;
        end else begin
            state  <= state_next;
            err_rd <= err_rd_next;
        end
    end

    always_comb begin
        state_next  = IDLE;
        err_rd_next = 1'b0;
        case ({wr_en, rd_en})
            2'b10: state_next = full ? WR_ERR : WR;
            2'b01: state_next = empty ? RD_ERR : RD;
            2'b11: begin
                if (empty) begin
                    state_next  = WR_RD_ERR;
                    err_rd_next = 1'b1;
                end else if (full) begin
                    state_next  = WR_RD_ERR;
                end else begin
                    state_next  = WR_RD;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Occupancy moves only when exactly one side is accepted
    always_comb begin
        count_next = count;
        if (push_ok && !pop_ok) begin
            count_next = count + CNT_W'(1);
        end else if (pop_ok && !push_ok) begin
            count_next = count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            d_out <= '0;
        end else begin
            count <= count_next;
            if (push_ok) begin
                tail <= tail + ADDR_W'(1);
            end
            if (pop_ok) begin
                head  <= head + ADDR_W'(1);
                d_out <= rData;
            end
        end
    end

endmodule
